// File: rtl/dw_conv_pkg.sv
// Shared widths, types and helpers for the depthwise / pointwise convolution engines.
package dw_conv_pkg;

  localparam int PIX_W       = 8;
  localparam int WT_W        = 8;
  localparam int PROD_W      = 17;
  localparam int SUM_W       = 21;
  localparam int ACC_W       = 32;
  localparam int MULT_W      = 16;
  localparam int SHIFT_W     = 5;
  localparam int KERNEL_TAPS = 9;

  typedef logic        [PIX_W-1:0]  pix_t;
  typedef logic signed [WT_W-1:0]   wt_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef struct packed {
    acc_t               bias;
    logic [MULT_W-1:0]  mult;
    logic [SHIFT_W-1:0] shift;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{bias: '0, mult: 16'd1, shift: '0};

  // Pixel is zero-extended so an unsigned 255 stays positive in the signed product.
  function automatic prod_t tap_mul(input pix_t p, input wt_t w);
    prod_t a;
    prod_t b;
    a = prod_t'($signed({1'b0, p}));
    b = prod_t'(w);
    return a * b;
  endfunction

endpackage

// File: rtl/dw_conv3x3_engine_requant.sv
// Two-stage requantiser: acc*mult, round-half-up, arithmetic shift, clamp to [0, CLAMP_MAX].
module dw_requant
  import dw_conv_pkg::*;
#(
  parameter int CLAMP_MAX = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic [MULT_W-1:0]   mult_in,
  input  logic [SHIFT_W-1:0]  shift_in,
  output logic [PIX_W-1:0]    pixel_out,
  output logic                pixel_out_valid
);

  localparam logic signed [48:0] CLAMP_LIM = 49'(CLAMP_MAX);
  localparam pix_t               CLAMP_PIX = pix_t'(CLAMP_MAX);

  logic signed [47:0] prod_next;
  logic signed [47:0] s3_prod;
  logic [SHIFT_W-1:0] s3_shift;
  logic               s3_valid;

  logic signed [48:0] rnd_add;
  logic signed [48:0] rnd;
  logic signed [48:0] shifted;
  pix_t               clamped;

  // |acc*mult| < 2^47, so the 48-bit product is exact.
  assign prod_next = 48'(acc_in) * 48'($signed({1'b0, mult_in}));

  always_ff @(posedge clock) begin
    if (reset) begin
      s3_prod  <= '0;
      s3_shift <= '0;
      s3_valid <= 1'b0;
    end else begin
      s3_valid <= in_valid;
      if (in_valid) begin
        s3_prod  <= prod_next;
        s3_shift <= shift_in;
      end
    end
  end

  always_comb begin
    rnd_add = '0;
    if (s3_shift != '0) begin
      rnd_add = 49'sd1 <<< (s3_shift - 5'd1);
    end
    rnd     = 49'(s3_prod) + rnd_add;
    shifted = rnd >>> s3_shift;
    if (shifted[48]) begin
      clamped = '0;
    end else if (shifted > CLAMP_LIM) begin
      clamped = CLAMP_PIX;
    end else begin
      clamped = shifted[PIX_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
    end else begin
      pixel_out_valid <= s3_valid;
      if (s3_valid) begin
        pixel_out <= clamped;
      end
    end
  end

endmodule

// File: rtl/dw_conv3x3_engine.sv
// Depthwise 3x3 convolution for one channel: products, adder tree + bias, requantise; 4-cycle latency.
module dw_conv3x3_engine
  import dw_conv_pkg::*;
#(
  parameter int CLAMP_MAX = 255,
  parameter int LATENCY   = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [KERNEL_TAPS-1:0][PIX_W-1:0]     window_in,
  input  logic                                  window_valid,
  input  logic                                  wt_valid,
  input  logic signed [WT_W-1:0]                wt_data,
  input  logic                                  cfg_valid,
  input  logic signed [ACC_W-1:0]               bias_in,
  input  logic [MULT_W-1:0]                     mult_in,
  input  logic [SHIFT_W-1:0]                    shift_in,
  output logic [PIX_W-1:0]                      pixel_out,
  output logic                                  pixel_out_valid,
  output logic                                  weights_loaded
);

  if (LATENCY != 4) begin : g_latency_check
    $error("dw_conv3x3_engine: LATENCY must be 4");
  end

  logic [3:0] wt_idx;
  wt_t        shadow [KERNEL_TAPS];
  wt_t        active [KERNEL_TAPS];
  logic       commit;
  cfg_t       cfg_act;

  // Commit copies shadow as it stood before this edge, so a back-to-back
  // write to shadow[0] in the commit cycle belongs to the next set.
  always_ff @(posedge clock) begin
    if (reset) begin
      wt_idx         <= '0;
      commit         <= 1'b0;
      weights_loaded <= 1'b0;
      cfg_act        <= CFG_RESET;
      for (int unsigned i = 0; i < KERNEL_TAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      commit <= 1'b0;
      if (wt_valid) begin
        shadow[wt_idx] <= wt_data;
        if (wt_idx == 4'd8) begin
          wt_idx <= '0;
          commit <= 1'b1;
        end else begin
          wt_idx <= wt_idx + 4'd1;
        end
      end
      if (commit) begin
        for (int unsigned i = 0; i < KERNEL_TAPS; i++) begin
          active[i] <= shadow[i];
        end
        weights_loaded <= 1'b1;
      end
      if (cfg_valid) begin
        cfg_act <= '{bias: bias_in, mult: mult_in, shift: shift_in};
      end
    end
  end

  prod_t s1_prod [KERNEL_TAPS];
  cfg_t  s1_cfg;
  logic  s1_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_cfg   <= CFG_RESET;
      for (int unsigned i = 0; i < KERNEL_TAPS; i++) begin
        s1_prod[i] <= '0;
      end
    end else begin
      s1_valid <= window_valid;
      if (window_valid) begin
        s1_cfg <= cfg_act;
        for (int unsigned i = 0; i < KERNEL_TAPS; i++) begin
          s1_prod[i] <= tap_mul(window_in[i], active[i]);
        end
      end
    end
  end

  sum_t               tree_sum;
  acc_t               s2_acc;
  logic [MULT_W-1:0]  s2_mult;
  logic [SHIFT_W-1:0] s2_shift;
  logic               s2_valid;

  always_comb begin
    tree_sum = '0;
    for (int unsigned i = 0; i < KERNEL_TAPS; i++) begin
      tree_sum = tree_sum + sum_t'(s1_prod[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_acc   <= '0;
      s2_mult  <= 16'd1;
      s2_shift <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_acc   <= acc_t'(tree_sum) + s1_cfg.bias;
        s2_mult  <= s1_cfg.mult;
        s2_shift <= s1_cfg.shift;
      end
    end
  end

  dw_requant #(
    .CLAMP_MAX(CLAMP_MAX)
  ) u_requant (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (s2_valid),
    .acc_in         (s2_acc),
    .mult_in        (s2_mult),
    .shift_in       (s2_shift),
    .pixel_out      (pixel_out),
    .pixel_out_valid(pixel_out_valid)
  );

endmodule

// File: tb/tb_dw_conv3x3_engine.sv
// Scoreboard bench for dw_conv3x3_engine: event-level reference model, decoupled output monitor.
module tb_dw_conv3x3_engine;

  localparam int CLAMP = 255;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [8:0][7:0]  window_in = '0;
  logic             window_valid = 1'b0;
  logic             wt_valid = 1'b0;
  logic signed [7:0] wt_data = '0;
  logic             cfg_valid = 1'b0;
  logic signed [31:0] bias_in = '0;
  logic [15:0]      mult_in = '0;
  logic [4:0]       shift_in = '0;
  logic [7:0]       pixel_out;
  logic             pixel_out_valid;
  logic             weights_loaded;

  dw_conv3x3_engine #(
    .CLAMP_MAX(CLAMP),
    .LATENCY  (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .window_in      (window_in),
    .window_valid   (window_valid),
    .wt_valid       (wt_valid),
    .wt_data        (wt_data),
    .cfg_valid      (cfg_valid),
    .bias_in        (bias_in),
    .mult_in        (mult_in),
    .shift_in       (shift_in),
    .pixel_out      (pixel_out),
    .pixel_out_valid(pixel_out_valid),
    .weights_loaded (weights_loaded)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int due;
    int val;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: kernels as whole arrays, changes applied by cycle of effect.
  int m_px[9];
  int act_k[9];
  int sh_k[9];
  int pend_k[9];
  bit pend;
  int pend_eff;
  int widx;
  bit m_wl;
  int m_bias, m_mult, m_shift;

  bit do_win, do_wt, do_cfg, do_rst;
  int s_wd, s_b, s_m, s_s;

  function automatic int ref_pixel(input int px[9], input int k[9], input int b,
                                   input int m, input int s);
    longint dot;
    int     acc;
    longint p;
    dot = 0;
    for (int i = 0; i < 9; i++) dot += longint'(px[i]) * longint'(k[i]);
    acc = int'(dot) + b;
    p = longint'(acc) * longint'(m);
    if (s > 0) p += longint'(1) << (s - 1);
    p = p >>> s;
    if (p < 0) return 0;
    if (p > CLAMP) return CLAMP;
    return int'(p);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      act_k[i] = 0;
      sh_k[i]  = 0;
    end
    pend    = 1'b0;
    widx    = 0;
    m_wl    = 1'b0;
    m_bias  = 0;
    m_mult  = 1;
    m_shift = 0;
  endtask

  // One clock cycle: drive the requested events and advance the model.
  task automatic step();
    @(posedge clock);
    #1;
    if (pend && cyc >= pend_eff) begin
      act_k = pend_k;
      pend  = 1'b0;
      m_wl  = 1'b1;
    end
    check("weights_loaded", int'(weights_loaded), int'(m_wl));
    reset        = do_rst;
    window_valid = do_win;
    for (int i = 0; i < 9; i++) window_in[i] = m_px[i][7:0];
    wt_valid  = do_wt;
    wt_data   = s_wd[7:0];
    cfg_valid = do_cfg;
    bias_in   = s_b;
    mult_in   = s_m[15:0];
    shift_in  = s_s[4:0];
    if (do_rst) begin
      model_reset();
      while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
    end
    if (do_win) sb.push_back('{cyc + 4, ref_pixel(m_px, act_k, m_bias, m_mult, m_shift)});
    if (do_cfg) begin
      m_bias  = s_b;
      m_mult  = s_m;
      m_shift = s_s;
    end
    if (do_wt) begin
      sh_k[widx] = s_wd;
      if (widx == 8) begin
        pend_k   = sh_k;
        pend     = 1'b1;
        pend_eff = cyc + 2;
        widx     = 0;
      end else begin
        widx++;
      end
    end
    do_win = 0; do_wt = 0; do_cfg = 0; do_rst = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_cfg(input int b, input int m, input int s);
    do_cfg = 1; s_b = b; s_m = m; s_s = s;
    step();
  endtask

  task automatic set_win(input int v);
    for (int i = 0; i < 9; i++) m_px[i] = v;
  endtask

  task automatic windows(input int n);
    repeat (n) begin
      do_win = 1;
      step();
    end
  endtask

  task automatic load_kernel(input int k[9]);
    for (int i = 0; i < 9; i++) begin
      do_wt = 1; s_wd = k[i];
      step();
    end
    idle(2);
  endtask

  task automatic load_const(input int v);
    int k[9];
    for (int i = 0; i < 9; i++) k[i] = v;
    load_kernel(k);
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      n_cmp++;
      if (!pixel_out_valid || int'(pixel_out) != sb[0].val) begin
        n_bad++;
        $display("FAIL pixel_out: got valid=%0b value=%0d expected valid=1 value=%0d (cycle %0d)",
                 pixel_out_valid, pixel_out, sb[0].val, cyc);
      end
      void'(sb.pop_front());
    end else if (pixel_out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL spurious_valid: got valid=1 value=%0d expected valid=0 (cycle %0d)",
               pixel_out, cyc);
    end
  end

  initial begin
    int k[9];
    model_reset();
    set_win(0);
    s_wd = 0; s_b = 0; s_m = 1; s_s = 0;
    do_rst = 1; step();
    do_rst = 1; step();
    step();
    @(negedge clock);
    check("reset_pixel_out", int'(pixel_out), 0);
    check("reset_valid", int'(pixel_out_valid), 0);
    check("reset_weights_loaded", int'(weights_loaded), 0);

    // No kernel yet: output is bias alone
    set_cfg(50, 1, 0);
    set_win(7);
    windows(2);
    set_cfg(-5, 3, 0);
    windows(1);

    set_cfg(0, 1, 0);
    load_const(1);
    set_win(10);
    windows(3);
    load_const(-1);
    windows(1);
    load_const(127);
    set_win(255);
    windows(1);

    // Rounding on centre tap
    for (int i = 0; i < 9; i++) k[i] = (i == 4) ? 1 : 0;
    load_kernel(k);
    set_cfg(0, 1, 2);
    set_win(0);
    m_px[4] = 90; windows(1);
    m_px[4] = 89; windows(1);

    // Kernel swap mid-stream
    set_cfg(0, 1, 0);
    load_const(1);
    set_win(10);
    for (int c = 0; c < 20; c++) begin
      do_win = 1;
      if (c >= 5 && c < 14) begin
        do_wt = 1; s_wd = 2;
      end
      step();
    end

    // Config change mid-stream
    for (int c = 0; c < 10; c++) begin
      do_win = 1;
      if (c == 4) begin
        do_cfg = 1; s_b = 100; s_m = 1; s_s = 0;
      end
      step();
    end

    // Back-to-back weight sets under a window stream
    set_cfg(10, 3, 2);
    for (int c = 0; c < 24; c++) begin
      do_win = 1;
      for (int i = 0; i < 9; i++) m_px[i] = int'($urandom_range(255));
      if (c < 18) begin
        do_wt = 1; s_wd = int'($urandom_range(255)) - 128;
      end
      step();
    end

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      do_win = ($urandom_range(3) != 0);
      for (int i = 0; i < 9; i++) m_px[i] = int'($urandom_range(255));
      if ($urandom_range(3) == 0) begin
        do_wt = 1; s_wd = int'($urandom_range(255)) - 128;
      end
      if ($urandom_range(19) == 0) begin
        do_cfg = 1;
        s_b = ($urandom_range(7) == 0) ? int'($urandom) : int'($urandom_range(4000)) - 2000;
        s_m = int'($urandom_range(300));
        s_s = int'($urandom_range(4, 14));
        if ($urandom_range(9) == 0) begin
          s_m = int'($urandom_range(65535));
          s_s = int'($urandom_range(31));
        end
      end
      step();
    end

    // Reset with windows in flight and a partial kernel load
    set_cfg(0, 1, 0);
    load_const(3);
    while (widx != 0) begin
      do_wt = 1; s_wd = 0; step();
    end
    idle(2);
    set_win(20);
    for (int c = 0; c < 5; c++) begin
      do_wt = 1; s_wd = 5;
      do_win = (c >= 2);
      step();
    end
    do_rst = 1; step();
    idle(6);
    check("weights_loaded_after_reset", int'(weights_loaded), 0);

    load_const(1);
    set_win(10);
    windows(2);
    idle(8);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
